// File: rtl/uart_vram_loader.sv
// Framed command parser between uart_rx and the VRAM write port.
// Frames: A5 01 ah al (set address) | A5 02 lh ll d... (stream write) | A5 03 lh ll v (fill).
module uart_vram_loader #(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DATA_W         = 6,
  parameter int unsigned VRAM_DEPTH     = 30000,
  parameter int unsigned TIMEOUT_CYCLES = 1066667
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              rx_ack,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        err_count,
  output logic              activity
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_DEPTH - 1);
  localparam logic [16:0]       DEPTH_17  = 17'(VRAM_DEPTH);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_SET   = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_FILL  = 8'h03;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_FILL_VAL,
    S_DATA,
    S_FILL_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         hi_q, hi_d;
  logic               fill_q, fill_d;
  logic [DATA_W-1:0]  val_q, val_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               rx_ack_q, rx_ack_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic               ferr_q, ferr_d;
  logic [7:0]         ecnt_q, ecnt_d;
  logic               act_q, act_d;

  logic               accept_c;
  logic               err_c;
  logic               done_c;
  logic [ADDR_W-1:0]  ptr_inc_c;
  logic [15:0]        word_c;

  assign rx_ack     = rx_ack_q;
  assign vram_we    = we_q;
  assign vram_addr  = addr_q;
  assign vram_wdata = wdata_q;
  assign busy       = busy_q;
  assign frame_err  = ferr_q;
  assign err_count  = ecnt_q;
  assign activity   = act_q;

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      hi_q     <= '0;
      fill_q   <= 1'b0;
      val_q    <= '0;
      tmo_q    <= '0;
      rx_ack_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ecnt_q   <= '0;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      hi_q     <= hi_d;
      fill_q   <= fill_d;
      val_q    <= val_d;
      tmo_q    <= tmo_d;
      rx_ack_q <= rx_ack_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
      ecnt_q   <= ecnt_d;
      act_q    <= act_d;
    end
  end

  // Frame decode, write generation, idle timeout and error bookkeeping
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    hi_d     = hi_q;
    fill_d   = fill_q;
    val_d    = val_q;
    tmo_d    = tmo_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ferr_d   = 1'b0;
    ecnt_d   = ecnt_q;
    act_d    = act_q;
    err_c    = 1'b0;
    done_c   = 1'b0;

    // No bytes are taken while the fill engine owns the write port
    accept_c  = rx_valid && !rx_ack_q && (state_q != S_FILL_RUN);
    rx_ack_d  = accept_c;
    ptr_inc_c = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);
    word_c    = {hi_q, rx_byte};

    case (state_q)
      S_IDLE: begin
        if (accept_c && rx_byte == SYNC_BYTE) state_d = S_CMD;
      end
      S_CMD: begin
        if (accept_c) begin
          if (rx_byte == CMD_SET) begin
            state_d = S_ADDR_HI;
          end else if (rx_byte == CMD_WRITE || rx_byte == CMD_FILL) begin
            fill_d  = (rx_byte == CMD_FILL);
            state_d = S_LEN_HI;
          end else begin
            err_c   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_ADDR_HI, S_LEN_HI: begin
        if (accept_c) begin
          hi_d    = rx_byte;
          state_d = (state_q == S_ADDR_HI) ? S_ADDR_LO : S_LEN_LO;
        end
      end
      S_ADDR_LO: begin
        if (accept_c) begin
          if (17'(word_c) < DEPTH_17) begin
            ptr_d  = ADDR_W'(word_c);
            done_c = 1'b1;
          end else begin
            err_c  = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      S_LEN_LO: begin
        if (accept_c) begin
          len_d = word_c;
          if (word_c == 16'd0) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = fill_q ? S_FILL_VAL : S_DATA;
          end
        end
      end
      S_FILL_VAL: begin
        if (accept_c) begin
          val_d   = rx_byte[DATA_W-1:0];
          state_d = S_FILL_RUN;
        end
      end
      S_DATA: begin
        if (accept_c) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = rx_byte[DATA_W-1:0];
          ptr_d   = ptr_inc_c;
          len_d   = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_FILL_RUN: begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = val_q;
        ptr_d   = ptr_inc_c;
        len_d   = len_q - LEN_W'(1);
        if (len_q == LEN_W'(1)) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte gap limit; only runs while waiting on the host mid-frame
    if (state_q != S_IDLE && state_q != S_FILL_RUN) begin
      if (accept_c) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        err_c   = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end

    if (err_c) begin
      ferr_d = 1'b1;
      if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
    end
    if (done_c) act_d = ~act_q;

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: doc/uart_vram_loader.md
Name: uart_vram_loader

Overview:
- Framed command parser between `uart_rx` and the VRAM user write port.
- Takes received bytes through the `uart_rx` data_ready/data_ack handshake and decodes a small command protocol: set address, stream write, fill.
- Drives one-cycle VRAM write strobes.
- Replaces the free-running single-byte write loop, so a host can write any region of the 200x150 framebuffer and recover sync after line noise.

Parameters:
- ADDR_W, 15, VRAM address width.
- DATA_W, 6, VRAM pixel width (RRGGBB).
- VRAM_DEPTH, 30000, number of valid VRAM words; legal addresses are 0..VRAM_DEPTH-1.
- TIMEOUT_CYCLES, 1066667, idle-gap limit inside a frame (about 10 ms at 106.67 MHz).

Ports:
- clk  in  1  system clock (clk106m domain).
- rst_n  in  1  asynchronous active-low reset.
- rx_byte  in  8  byte from uart_rx.
- rx_valid  in  1  uart_rx data_ready; level, held until acknowledged.
- rx_ack  out  1  one-cycle acknowledge to uart_rx data_ack.
- vram_we  out  1  write strobe, one word per cycle.
- vram_addr  out  ADDR_W  write address.
- vram_wdata  out  DATA_W  write data.
- busy  out  1  high in any state other than IDLE.
- frame_err  out  1  one-cycle pulse on any protocol error.
- err_count  out  8  saturating error counter.
- activity  out  1  toggles once per completed frame (LED).

Behaviour:
- Reset values: rx_ack=0, vram_we=0, vram_addr=0, vram_wdata=0, busy=0, frame_err=0, err_count=0, activity=0. The internal address pointer is 0 and the state is IDLE.
- Byte accept rule: a byte is accepted on a cycle where rx_valid=1, rx_ack=0, and the state consumes bytes.
  - rx_ack is registered high on the next cycle for exactly one cycle.
  - No second accept can occur while rx_ack=1.
- Frame formats:
  - Every frame starts with sync byte 0xA5, then a command byte.
  - 0x01 SET_ADDR: addr_hi, addr_lo.
  - 0x02 WRITE: len_hi, len_lo, then len data bytes.
  - 0x03 FILL: len_hi, len_lo, value.
  - Data and value bytes use bits [DATA_W-1:0]; upper bits are ignored.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, FILL_VAL, DATA, FILL_RUN.
- IDLE: a byte of 0xA5 goes to CMD. Any other byte is discarded silently (no error).
- CMD:
  - 0x01 goes to ADDR_HI.
  - 0x02 and 0x03 go to LEN_HI; the command is latched.
  - Any other value is an error and returns to IDLE.
- ADDR_LO:
  - If the 16-bit address is < VRAM_DEPTH, load the pointer and complete the frame.
  - Otherwise raise an error; the pointer is unchanged.
  - Either way, return to IDLE.
- LEN_LO:
  - len=0 completes the frame with no writes and returns to IDLE.
  - Otherwise WRITE goes to DATA and FILL goes to FILL_VAL.
- DATA:
  - Each accepted byte produces vram_we=1 in the cycle after accept, with vram_addr = pointer and vram_wdata = byte[DATA_W-1:0].
  - The pointer and remaining length update in the same cycle.
  - When the last byte is written, complete the frame and return to IDLE.
- FILL_VAL: the accepted value is latched, then go to FILL_RUN.
- FILL_RUN:
  - Writes the value once per cycle: len consecutive cycles of vram_we=1.
  - No bytes are accepted (rx_ack stays 0).
  - Then complete the frame and return to IDLE.
- Pointer wrap: after writing address VRAM_DEPTH-1 the pointer becomes 0. Lengths larger than VRAM_DEPTH simply wrap repeatedly.
- The pointer persists across frames: WRITE/FILL continue from wherever the last write ended.
- Outputs: vram_we is a registered single-cycle strobe; vram_addr and vram_wdata are valid only when vram_we=1.
- Timeout:
  - In any state other than IDLE and FILL_RUN, a counter increments each cycle and clears on every accept.
  - When it reaches TIMEOUT_CYCLES, raise an error and go to IDLE.
  - Writes already performed are kept.
- Error action: frame_err pulses one cycle and err_count increments, saturating at 255.
- Frame completion: activity toggles one cycle after the last action of a frame.
- Reset mid-frame or mid-fill: returns immediately to IDLE. In-progress writes stop; vram_we drops asynchronously.
- A byte of 0xA5 received inside DATA is treated as data, not as a resync.

Test Plan:
- Reset, then stream A5 01 00 0A, then A5 02 00 03 3F 15 C2.
  - Required: writes to addr 10, 11, 12 with data 0x3F, 0x15, 0x02.
  - Required: activity toggles twice; err_count=0.
- Pointer at 29998, then A5 02 00 03 01 02 03.
  - Required: writes to 29998, 29999, 0 (wrap).
  - Required: pointer ends at 1.
- A5 03 75 30 2A (len=30000).
  - Required: 30000 consecutive vram_we cycles, all with data 0x2A.
  - Required: rx_valid asserted during the run gets no rx_ack until IDLE.
- Error frames:
  - A5 07: frame_err pulse, err_count=1.
  - A5 01 75 30: err_count=2, pointer unchanged.
  - Noise 00 FF before A5: no error.
- A5 02 00 05 11 then silence for TIMEOUT_CYCLES.
  - Required: exactly one write, then frame_err and IDLE.
  - Required: a following A5 01 00 00 frame works.
- Assert rst_n=0 midway through a FILL of len=1000.
  - Required: vram_we=0 immediately; all outputs return to reset values.
  - Required: normal operation after release.
